// File: rtl/pipe_pkg.sv
// Shared pipeline types: register index, scoreboard slot record and the bubble constant.
package pipe_pkg;

  typedef logic [3:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    logic     wb_en;
    logic     is_mem;
    logic     is_load;
    reg_idx_t dest;
  } sb_slot_t;

  localparam sb_slot_t SB_BUBBLE = '0;

  // True when an in-flight writer produces one of the live decode operands.
  function automatic logic slot_match(sb_slot_t s, reg_idx_t src1, reg_idx_t src2,
                                      logic two_src);
    return s.valid & s.wb_en & ((s.dest == src1) | (two_src & (s.dest == src2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: shadow pipeline of in-flight writers, hazard/freeze and perf counters.
// Define FORWARDING_EN to restrict hazard detection to load-use in EXE.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_w_en,
  input  logic [3:0]       id_dest,
  input  logic             flush,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  sb_slot_t slots_q [STAGES];
  logic     pend_flush_q;
  sb_slot_t id_rec;
  logic     any_match;
  logic     squash;

  always_comb begin
    id_rec         = SB_BUBBLE;
    id_rec.valid   = 1'b1;
    id_rec.wb_en   = id_wb_en;
    id_rec.is_mem  = id_mem_r_en | id_mem_w_en;
    id_rec.is_load = id_mem_r_en;
    id_rec.dest    = id_dest;
  end

  always_comb begin
    any_match = 1'b0;
`ifdef FORWARDING_EN
    any_match = slots_q[0].is_load & slot_match(slots_q[0], src1, src2, two_src);
`else
    // WB slot is included: its register file write only lands at this edge.
    for (int i = 0; i < STAGES; i++) begin
      any_match = any_match | slot_match(slots_q[i], src1, src2, two_src);
    end
`endif
  end

  assign hazard = id_valid & any_match & ~flush;
  assign freeze = slots_q[1].valid & slots_q[1].is_mem & ~mem_ready;
  assign squash = flush | pend_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        slots_q[i] <= SB_BUBBLE;
      end
      pend_flush_q <= 1'b0;
    end else if (freeze) begin
      // Nothing moves; remember a branch flush for the first cycle that does.
      if (flush) begin
        pend_flush_q <= 1'b1;
      end
    end else begin
      slots_q[0] <= (id_valid & ~hazard & ~squash) ? id_rec : SB_BUBBLE;
      for (int i = 1; i < STAGES; i++) begin
        slots_q[i] <= slots_q[i-1];
      end
      pend_flush_q <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .en (hazard),
    .clr(rst),
    .q  (stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_freeze_cnt (
    .clk(clk),
    .en (freeze),
    .clr(rst),
    .q  (freeze_cnt)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second instance with 4-bit counters checks saturation.
module tb_hazard_scoreboard;
  import pipe_pkg::*;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        id_wb_en;
  logic        id_mem_r_en;
  logic        id_mem_w_en;
  logic [3:0]  id_dest;
  logic        flush;
  logic        mem_ready;
  logic        hazard;
  logic        freeze;
  logic [15:0] stall_cnt;
  logic [15:0] freeze_cnt;
  logic        hazard4;
  logic        freeze4;
  logic [3:0]  stall_cnt4;
  logic [3:0]  freeze_cnt4;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_freeze = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .src1       (src1),
    .src2       (src2),
    .two_src    (two_src),
    .id_wb_en   (id_wb_en),
    .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en),
    .id_dest    (id_dest),
    .flush      (flush),
    .mem_ready  (mem_ready),
    .hazard     (hazard),
    .freeze     (freeze),
    .stall_cnt  (stall_cnt),
    .freeze_cnt (freeze_cnt)
  );

  hazard_scoreboard #(
    .STAGES(3),
    .CNT_W (4)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .src1       (src1),
    .src2       (src2),
    .two_src    (two_src),
    .id_wb_en   (id_wb_en),
    .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en),
    .id_dest    (id_dest),
    .flush      (flush),
    .mem_ready  (mem_ready),
    .hazard     (hazard4),
    .freeze     (freeze4),
    .stall_cnt  (stall_cnt4),
    .freeze_cnt (freeze_cnt4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hz(input string tag, input int exp);
    chk(tag, 32'(hazard), 32'(exp));
    if (exp != 0) exp_stall++;
  endtask

  task automatic chk_fz(input string tag, input int exp);
    chk(tag, 32'(freeze), 32'(exp));
    if (exp != 0) exp_freeze++;
  endtask

  task automatic dec(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                     input logic wb, input logic mr, input logic mw, input logic [3:0] d);
    id_valid    = v;
    src1        = s1;
    src2        = s2;
    two_src     = two;
    id_wb_en    = wb;
    id_mem_r_en = mr;
    id_mem_w_en = mw;
    id_dest     = d;
  endtask

  task automatic idle();
    dec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    mem_ready = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("reset_hazard", 32'(hazard), 0);
    chk("reset_freeze", 32'(freeze), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_freeze_cnt", 32'(freeze_cnt), 0);
    chk("reset_slot0_valid", 32'(dut.slots_q[0].valid), 0);

    // RAW: ADD R1,R2,R3 then SUB R2,R1,R3
    dec(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    #2 chk_hz("raw_producer", 0);
    tick();
    dec(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
    #2 chk_hz("raw_c1", FWD ? 0 : 1);
    tick();
    #2 chk_hz("raw_c2", FWD ? 0 : 1);
    tick();
    #2 chk_hz("raw_c3", FWD ? 0 : 1);
    tick();
    #2 chk_hz("raw_c4_release", 0);
    chk("raw_stall_cnt", 32'(stall_cnt), FWD ? 0 : 3);
    tick();
    drain();

    // Dest R15 tracked; src2 ignored unless two_src
    dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
    tick();
    dec(1'b1, 4'd0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    #1 chk("r15_src2_dead", 32'(hazard), 0);
    src1 = 4'hF;
    #1 chk_hz("r15_src1", FWD ? 0 : 1);
    tick();
    drain();
    chk("r15_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Store after MOV R6: dependency on src2 only
    dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    tick();
    dec(1'b1, 4'd0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    #1 chk("str_two_src_off", 32'(hazard), 0);
    two_src = 1'b1;
    #1 chk_hz("str_c1", FWD ? 0 : 1);
    tick();
    #2 chk_hz("str_c2", FWD ? 0 : 1);
    tick();
    #2 chk_hz("str_c3", FWD ? 0 : 1);
    tick();
    #2 chk_hz("str_retired", 0);
    tick();
    drain();
    chk("str_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Load-use: LDR R4 then ADD R5,R4,R4
    dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    tick();
    dec(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
    #2 chk_hz("ldu_c1", 1);
    tick();
    #2 chk_hz("ldu_c2", FWD ? 0 : 1);
    tick();
    #2 chk_hz("ldu_c3", FWD ? 0 : 1);
    tick();
    #2 chk_hz("ldu_c4", 0);
    chk("ldu_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    tick();
    drain();

    // Memory wait: LDR R4 held in MEM for 5 cycles, flush pulsed mid-freeze
    dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    tick();
    idle();
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2);
      if (i == 2) dec(1'b1, 4'd8, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
      else idle();
      #2 chk_fz("mw_freeze", 1);
      chk("mw_slot1_valid", 32'(dut.slots_q[1].valid), 1);
      chk("mw_slot1_dest", 32'(dut.slots_q[1].dest), 4);
      if (i == 3) chk("mw_pend_flush", 32'(dut.pend_flush_q), 1);
      tick();
    end
    flush = 1'b0;
    mem_ready = 1'b1;
    dec(1'b1, 4'd8, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
    #2 chk_fz("mw_released", 0);
    chk("mw_freeze_cnt", 32'(freeze_cnt), 32'(exp_freeze));
    chk("mw_freeze_cnt5", 32'(freeze_cnt), 5);
    tick();
    idle();
    #2 chk("pf_slot0_bubble", 32'(dut.slots_q[0].valid), 0);
    chk("pf_cleared", 32'(dut.pend_flush_q), 0);
    chk("pf_ldr_in_wb", 32'(dut.slots_q[2].dest), 4);
    chk("pf_ldr_wb_valid", 32'(dut.slots_q[2].valid), 1);
    drain();

    // Reset while frozen
    dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    tick();
    idle();
    mem_ready = 1'b0;
    tick();
    #2 chk_fz("rf_frozen", 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_stall = 0;
    exp_freeze = 0;
    dec(1'b1, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
    #2 chk("rf_freeze", 32'(freeze), 0);
    chk("rf_hazard", 32'(hazard), 0);
    chk("rf_stall_cnt", 32'(stall_cnt), 0);
    chk("rf_freeze_cnt", 32'(freeze_cnt), 0);
    chk("rf_freeze_cnt4", 32'(freeze_cnt4), 0);
    tick();

    // Saturation: LDR R4, LDR R5, then a consumer of R5 held by a frozen MEM
    mem_ready = 1'b1;
    dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    tick();
    dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
    tick();
    mem_ready = 1'b0;
    dec(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    for (int i = 0; i < 20; i++) begin
      #2 chk_hz("sat_hazard", 1);
      chk_fz("sat_freeze", 1);
      tick();
    end
    #2 chk("sat_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    chk("sat_freeze_cnt", 32'(freeze_cnt), 32'(exp_freeze));
    chk("sat_stall_cnt4", 32'(stall_cnt4), (exp_stall > 15) ? 15 : 32'(exp_stall));
    chk("sat_freeze_cnt4", 32'(freeze_cnt4), (exp_freeze > 15) ? 15 : 32'(exp_freeze));
    chk("sat_stall_cnt4_15", 32'(stall_cnt4), 15);
    mem_ready = 1'b1;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
